// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and a DMA/debug burst port.
// Latency: core grant and memory access in the request cycle, read data one cycle later; DMA beats start the cycle after dma_gnt_o.
// Backpressure: requests are held until granted; the core is locked out for the whole DMA burst, and round-robin priority alternates on contention.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   core_*_i / core_*_o      single-word core access: req/we/addr/wdata in; gnt, rvalid, rdata, err out
//   dma_*_i / dma_*_o        burst port: req/we/addr/len/wdata in; gnt, wready, rvalid, rdata, done, err out
//   mem_*_o, MemWrite_o,
//   MemRead_o, mem_rdata_i   drive of the single-port memory, combinational read data back
module dmem_arbiter #(
    parameter int DEPTH = 32,
    parameter int LENW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [31:0]     core_addr_i,
    input  logic [31:0]     core_wdata_i,
    output logic            core_gnt_o,
    output logic            core_rvalid_o,
    output logic [31:0]     core_rdata_o,
    output logic            core_err_o,
    input  logic            dma_req_i,
    input  logic            dma_we_i,
    input  logic [31:0]     dma_addr_i,
    input  logic [LENW-1:0] dma_len_i,
    input  logic [31:0]     dma_wdata_i,
    output logic            dma_gnt_o,
    output logic            dma_wready_o,
    output logic            dma_rvalid_o,
    output logic [31:0]     dma_rdata_o,
    output logic            dma_done_o,
    output logic            dma_err_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic            MemWrite_o,
    output logic            MemRead_o,
    input  logic [31:0]     mem_rdata_i
);

    typedef enum logic {ST_ARB, ST_BURST} state_e;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;          // 0: core favoured on contention
    logic [LENW-1:0]   cnt_q, cnt_d;        // beats remaining minus 1
    logic [31:0]       baddr_q, baddr_d;
    logic              bwe_q, bwe_d;
    logic              berr_q, berr_d;      // sticky out-of-range flag for the burst

    logic              crv_q, crv_d;
    logic [31:0]       crdata_q, crdata_d;
    logic              cerr_q, cerr_d;
    logic              drv_q, drv_d;
    logic [31:0]       drdata_q, drdata_d;
    logic              done_q, done_d;
    logic              derr_q, derr_d;

    logic              core_gnt, dma_gnt, dma_wready;
    logic [31:0]       mem_addr, mem_wdata;
    logic              mem_we, mem_re;
    logic              core_in_range, beat_in_range;

    assign core_in_range = (core_addr_i < DEPTH_W);
    assign beat_in_range = (baddr_q < DEPTH_W);

    always_comb begin
        core_gnt   = 1'b0;
        dma_gnt    = 1'b0;
        dma_wready = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        baddr_d    = baddr_q;
        bwe_d      = bwe_q;
        berr_d     = berr_q;
        crv_d      = 1'b0;
        crdata_d   = '0;
        cerr_d     = 1'b0;
        drv_d      = 1'b0;
        drdata_d   = '0;
        done_d     = 1'b0;
        derr_d     = 1'b0;

        // Everything memory-facing is gated by rst_n so an in-flight write
        // stops in the same cycle reset is asserted.
        if (rst_n) begin
            if (state_q == ST_BURST) begin
                mem_addr = baddr_q;
                if (bwe_q) begin
                    dma_wready = 1'b1;
                    mem_wdata  = dma_wdata_i;
                    mem_we     = beat_in_range;
                end else begin
                    mem_re   = beat_in_range;
                    drv_d    = 1'b1;
                    drdata_d = beat_in_range ? mem_rdata_i : 32'd0;
                end
                baddr_d = baddr_q + 32'd1;
                cnt_d   = cnt_q - 1'b1;
                berr_d  = berr_q | ~beat_in_range;
                if (cnt_q == '0) begin
                    state_d = ST_ARB;
                    rr_d    = 1'b0;
                    done_d  = 1'b1;
                    derr_d  = berr_q | ~beat_in_range;
                end
            end else begin
                core_gnt = core_req_i & (~dma_req_i | ~rr_q);
                dma_gnt  = dma_req_i & ~core_gnt;
                if (core_gnt) begin
                    mem_addr  = core_addr_i;
                    mem_wdata = core_wdata_i;
                    mem_we    = core_we_i & core_in_range;
                    mem_re    = ~core_we_i & core_in_range;
                    rr_d      = 1'b1;
                    crv_d     = 1'b1;
                    crdata_d  = (~core_we_i & core_in_range) ? mem_rdata_i : 32'd0;
                    cerr_d    = ~core_in_range;
                end
                // The grant cycle leaves the memory idle; beats start next cycle.
                if (dma_gnt) begin
                    state_d = ST_BURST;
                    cnt_d   = dma_len_i;
                    baddr_d = dma_addr_i;
                    bwe_d   = dma_we_i;
                    berr_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ARB;
            rr_q     <= 1'b0;
            cnt_q    <= '0;
            baddr_q  <= '0;
            bwe_q    <= 1'b0;
            berr_q   <= 1'b0;
            crv_q    <= 1'b0;
            crdata_q <= '0;
            cerr_q   <= 1'b0;
            drv_q    <= 1'b0;
            drdata_q <= '0;
            done_q   <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            baddr_q  <= baddr_d;
            bwe_q    <= bwe_d;
            berr_q   <= berr_d;
            crv_q    <= crv_d;
            crdata_q <= crdata_d;
            cerr_q   <= cerr_d;
            drv_q    <= drv_d;
            drdata_q <= drdata_d;
            done_q   <= done_d;
            derr_q   <= derr_d;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign core_rvalid_o = crv_q;
    assign core_rdata_o  = crdata_q;
    assign core_err_o    = cerr_q;
    assign dma_gnt_o     = dma_gnt;
    assign dma_wready_o  = dma_wready;
    assign dma_rvalid_o  = drv_q;
    assign dma_rdata_o   = drdata_q;
    assign dma_done_o    = done_q;
    assign dma_err_o     = derr_q;
    assign mem_addr_o    = mem_addr;
    assign mem_wdata_o   = mem_wdata;
    assign MemWrite_o    = mem_we;
    assign MemRead_o     = mem_re;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized traffic.
// A queue-based transaction model predicts every output each cycle; outputs are sampled on the falling edge.
// Requesters hold requests until granted and replace them in the cycle after a grant.
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int LENW  = 4;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        logic [31:0] addr;
        bit          we;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic core_gnt_o, core_rvalid_o, core_err_o;
    logic [31:0] core_rdata_o;
    logic dma_req_i, dma_we_i;
    logic [31:0] dma_addr_i, dma_wdata_i;
    logic [LENW-1:0] dma_len_i;
    logic dma_gnt_o, dma_wready_o, dma_rvalid_o, dma_done_o, dma_err_o;
    logic [31:0] dma_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic MemWrite_o, MemRead_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_len_i(dma_len_i), .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o),
        .dma_wready_o(dma_wready_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
        .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .MemWrite_o(MemWrite_o),
        .MemRead_o(MemRead_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Physical memory seen by the DUT; out-of-range reads return a poison value.
    logic [31:0] mem [DEPTH];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (MemWrite_o && mem_addr_o < 32'(DEPTH)) begin
            mem[mem_addr_o[AW-1:0]] <= mem_wdata_o;
        end
    end
    assign mem_rdata_i = (mem_addr_o < 32'(DEPTH)) ? mem[mem_addr_o[AW-1:0]] : 32'hBAD0_BAD0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending burst beats, a fairness bit and a model memory.
    logic [31:0] ref_mem [DEPTH];
    initial begin : model
        beat_t beats[$];
        beat_t b;
        bit m_rr, m_berr, inr;
        bit cg, dg, wr, mw, mr, acc;
        logic [31:0] ma, mwd;
        bit e_crv, e_cerr, e_drv, e_done, e_derr;
        logic [31:0] e_crd, e_drd;
        bit n_crv, n_cerr, n_drv, n_done, n_derr;
        logic [31:0] n_crd, n_drd;
        m_rr = 1'b0; m_berr = 1'b0;
        e_crv = 1'b0; e_cerr = 1'b0; e_drv = 1'b0; e_done = 1'b0; e_derr = 1'b0;
        e_crd = '0; e_drd = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_core_gnt", core_gnt_o, 1'b0);
                chk1("rst_dma_gnt", dma_gnt_o, 1'b0);
                chk1("rst_wready", dma_wready_o, 1'b0);
                chk1("rst_memwrite", MemWrite_o, 1'b0);
                chk1("rst_memread", MemRead_o, 1'b0);
                chk1("rst_core_rvalid", core_rvalid_o, 1'b0);
                chk32("rst_core_rdata", core_rdata_o, 32'd0);
                chk1("rst_core_err", core_err_o, 1'b0);
                chk1("rst_dma_rvalid", dma_rvalid_o, 1'b0);
                chk32("rst_dma_rdata", dma_rdata_o, 32'd0);
                chk1("rst_dma_done", dma_done_o, 1'b0);
                chk1("rst_dma_err", dma_err_o, 1'b0);
                beats.delete();
                m_rr = 1'b0; m_berr = 1'b0;
                e_crv = 1'b0; e_cerr = 1'b0; e_drv = 1'b0; e_done = 1'b0; e_derr = 1'b0;
                e_crd = '0; e_drd = '0;
            end else begin
                cg = 0; dg = 0; wr = 0; mw = 0; mr = 0; acc = 0; ma = '0; mwd = '0;
                n_crv = 0; n_cerr = 0; n_drv = 0; n_done = 0; n_derr = 0; n_crd = '0; n_drd = '0;
                if (beats.size() != 0) begin
                    b = beats.pop_front();
                    inr = (b.addr < 32'(DEPTH));
                    acc = 1; ma = b.addr;
                    if (b.we) begin
                        wr = 1; mw = inr; mwd = dma_wdata_i;
                        if (inr) ref_mem[b.addr[AW-1:0]] = dma_wdata_i;
                    end else begin
                        mr = inr; n_drv = 1;
                        n_drd = inr ? ref_mem[b.addr[AW-1:0]] : 32'd0;
                    end
                    if (!inr) m_berr = 1;
                    if (beats.size() == 0) begin
                        n_done = 1; n_derr = m_berr; m_rr = 0;
                    end
                end else if (core_req_i && (!dma_req_i || !m_rr)) begin
                    inr = (core_addr_i < 32'(DEPTH));
                    cg = 1; acc = 1; ma = core_addr_i; mwd = core_wdata_i;
                    mw = core_we_i && inr;
                    mr = !core_we_i && inr;
                    if (mw) ref_mem[core_addr_i[AW-1:0]] = core_wdata_i;
                    n_crv = 1; n_cerr = !inr;
                    n_crd = mr ? ref_mem[core_addr_i[AW-1:0]] : 32'd0;
                    m_rr = 1;
                end else if (dma_req_i) begin
                    dg = 1; m_berr = 0;
                    for (int i = 0; i <= int'(dma_len_i); i++)
                        beats.push_back('{addr: dma_addr_i + 32'(i), we: dma_we_i});
                end
                chk1("core_gnt", core_gnt_o, cg);
                chk1("dma_gnt", dma_gnt_o, dg);
                chk1("dma_wready", dma_wready_o, wr);
                chk1("MemWrite", MemWrite_o, mw);
                chk1("MemRead", MemRead_o, mr);
                if (mw || mr) chk32("mem_addr", mem_addr_o, ma);
                else if (!acc) chk32("mem_addr_idle", mem_addr_o, 32'd0);
                if (mw) chk32("mem_wdata", mem_wdata_o, mwd);
                else if (!acc) chk32("mem_wdata_idle", mem_wdata_o, 32'd0);
                chk1("core_rvalid", core_rvalid_o, e_crv);
                if (e_crv) begin
                    chk32("core_rdata", core_rdata_o, e_crd);
                    chk1("core_err", core_err_o, e_cerr);
                end
                chk1("dma_rvalid", dma_rvalid_o, e_drv);
                if (e_drv) chk32("dma_rdata", dma_rdata_o, e_drd);
                chk1("dma_done", dma_done_o, e_done);
                if (e_done) chk1("dma_err", dma_err_o, e_derr);
                e_crv = n_crv; e_crd = n_crd; e_cerr = n_cerr;
                e_drv = n_drv; e_drd = n_drd; e_done = n_done; e_derr = n_derr;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int nmr, nrv, viol, ncg, ndg;
        bit dn, de, cgs, dgs;
        byte last;
        rst_n = 1'b1;
        core_req_i = 0; core_we_i = 0; core_addr_i = '0; core_wdata_i = '0;
        dma_req_i = 0; dma_we_i = 0; dma_addr_i = '0; dma_len_i = '0; dma_wdata_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_core_rvalid", core_rvalid_o, 1'b0);
        chk1("reset_dma_done", dma_done_o, 1'b0);
        cyc(); rst_n = 1'b1;

        // Simultaneous requests after reset: core first, then DMA, then core waits out the burst.
        cyc();
        core_req_i = 1; core_we_i = 0; core_addr_i = 1;
        dma_req_i = 1; dma_we_i = 0; dma_addr_i = 0; dma_len_i = 1;
        @(negedge clk);
        chk1("arb_core_first", core_gnt_o, 1'b1);
        chk1("arb_dma_waits", dma_gnt_o, 1'b0);
        cyc(); core_addr_i = 2;
        @(negedge clk);
        chk1("arb_dma_second", dma_gnt_o, 1'b1);
        chk1("arb_core_blocked", core_gnt_o, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc(); dma_req_i = 0;
            @(negedge clk);
            chk1("core_blocked_in_burst", core_gnt_o, 1'b0);
        end
        cyc();
        @(negedge clk);
        chk1("arb_done_pulse", dma_done_o, 1'b1);
        chk1("arb_core_after_done", core_gnt_o, 1'b1);

        // Core write then read-back at address 5.
        cyc(); core_we_i = 1; core_addr_i = 5; core_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("cwr_gnt", core_gnt_o, 1'b1);
        chk1("cwr_memwrite", MemWrite_o, 1'b1);
        chk32("cwr_addr", mem_addr_o, 32'd5);
        cyc(); core_we_i = 0;
        @(negedge clk);
        chk1("crd_gnt", core_gnt_o, 1'b1);
        chk1("crd_memread", MemRead_o, 1'b1);
        chk1("cwr_rvalid", core_rvalid_o, 1'b1);
        chk32("cwr_rdata_zero", core_rdata_o, 32'd0);
        cyc(); core_req_i = 0;
        @(negedge clk);
        chk1("crd_rvalid", core_rvalid_o, 1'b1);
        chk32("crd_rdata", core_rdata_o, 32'hDEAD_BEEF);
        chk1("crd_err", core_err_o, 1'b0);

        // DMA write 1..4 at 8..11, then read back.
        cyc(); dma_req_i = 1; dma_we_i = 1; dma_addr_i = 8; dma_len_i = 3;
        @(negedge clk);
        chk1("dwr_gnt", dma_gnt_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(); dma_req_i = 0; dma_wdata_i = 32'(k + 1);
            @(negedge clk);
            chk1("dwr_wready", dma_wready_o, 1'b1);
            chk1("dwr_memwrite", MemWrite_o, 1'b1);
            chk32("dwr_addr", mem_addr_o, 32'(8 + k));
        end
        cyc();
        @(negedge clk);
        chk1("dwr_done", dma_done_o, 1'b1);
        chk1("dwr_err", dma_err_o, 1'b0);
        cyc(); dma_req_i = 1; dma_we_i = 0; dma_addr_i = 8; dma_len_i = 3;
        @(negedge clk);
        chk1("drd_gnt", dma_gnt_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(); dma_req_i = 0;
            @(negedge clk);
            chk1("drd_memread", MemRead_o, 1'b1);
            chk32("drd_addr", mem_addr_o, 32'(8 + k));
            if (k > 0) begin
                chk1("drd_rvalid", dma_rvalid_o, 1'b1);
                chk32("drd_rdata", dma_rdata_o, 32'(k));
            end
        end
        cyc();
        @(negedge clk);
        chk1("drd_last_rvalid", dma_rvalid_o, 1'b1);
        chk32("drd_last_rdata", dma_rdata_o, 32'd4);
        chk1("drd_done", dma_done_o, 1'b1);
        chk1("drd_err", dma_err_o, 1'b0);

        // Out-of-range core read and a DMA burst straddling the end of memory.
        cyc(); core_req_i = 1; core_we_i = 0; core_addr_i = 40;
        @(negedge clk);
        chk1("oor_core_gnt", core_gnt_o, 1'b1);
        chk1("oor_core_noread", MemRead_o, 1'b0);
        cyc(); core_req_i = 0; dma_req_i = 1; dma_we_i = 0; dma_addr_i = 30; dma_len_i = 3;
        @(negedge clk);
        chk1("oor_core_rvalid", core_rvalid_o, 1'b1);
        chk1("oor_core_err", core_err_o, 1'b1);
        chk32("oor_core_rdata", core_rdata_o, 32'd0);
        chk1("oor_dma_gnt", dma_gnt_o, 1'b1);
        nmr = 0; nrv = 0; dn = 0; de = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(); dma_req_i = 0;
            @(negedge clk);
            nmr += int'(MemRead_o);
            nrv += int'(dma_rvalid_o);
            if (dma_done_o) begin dn = 1; de = dma_err_o; end
        end
        chk32("oor_memread_count", 32'(nmr), 32'd2);
        chk32("oor_rvalid_count", 32'(nrv), 32'd4);
        chk1("oor_dma_done", dn, 1'b1);
        chk1("oor_dma_err", de, 1'b1);

        // Reset during a write burst, then a clean single-beat read.
        cyc(); dma_req_i = 1; dma_we_i = 1; dma_addr_i = 0; dma_len_i = 3;
        @(negedge clk);
        chk1("rstb_gnt", dma_gnt_o, 1'b1);
        for (int k = 0; k < 2; k++) begin
            cyc(); dma_req_i = 0; dma_wdata_i = 32'hA0 + 32'(k);
            @(negedge clk);
            chk1("rstb_memwrite", MemWrite_o, 1'b1);
        end
        cyc(); dma_wdata_i = 32'hA2; rst_n = 1'b0;
        @(negedge clk);
        chk1("rstb_memwrite_drop", MemWrite_o, 1'b0);
        chk1("rstb_wready_drop", dma_wready_o, 1'b0);
        cyc();
        cyc(); rst_n = 1'b1;
        cyc(); dma_req_i = 1; dma_we_i = 0; dma_addr_i = 0; dma_len_i = 0;
        @(negedge clk);
        chk1("post_rst_gnt", dma_gnt_o, 1'b1);
        cyc(); dma_req_i = 0;
        @(negedge clk);
        chk1("post_rst_read", MemRead_o, 1'b1);
        cyc();
        @(negedge clk);
        chk1("post_rst_done", dma_done_o, 1'b1);
        chk1("post_rst_err", dma_err_o, 1'b0);
        chk32("post_rst_rdata", dma_rdata_o, 32'hA0);

        // Continuous core requests against repeated single-beat DMA requests.
        cyc();
        core_req_i = 1; core_we_i = 0; core_addr_i = 3;
        dma_req_i = 1; dma_we_i = 0; dma_addr_i = 4; dma_len_i = 0;
        viol = 0; ncg = 0; ndg = 0; last = "?";
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (core_gnt_o) begin
                if (last == "C") viol++;
                last = "C"; ncg++;
            end
            if (dma_gnt_o) begin
                if (last == "D") viol++;
                last = "D"; ndg++;
            end
            cgs = core_gnt_o;
            cyc();
            if (cgs) core_addr_i = 32'($urandom_range(0, 31));
        end
        chk32("alt_violations", 32'(viol), 32'd0);
        chk1("alt_core_progress", ncg >= 9, 1'b1);
        chk1("alt_dma_progress", ndg >= 9, 1'b1);
        core_req_i = 0; dma_req_i = 0;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cgs = core_gnt_o;
            dgs = dma_gnt_o;
            cyc();
            rst_n = ($urandom_range(0, 499) != 0);
            if (!core_req_i || cgs) begin
                core_req_i   = ($urandom_range(0, 2) != 0);
                core_we_i    = $urandom_range(0, 1) != 0;
                core_addr_i  = 32'($urandom_range(0, 40));
                core_wdata_i = $urandom();
            end
            if (!dma_req_i || dgs) begin
                dma_req_i  = ($urandom_range(0, 3) == 0);
                dma_we_i   = $urandom_range(0, 1) != 0;
                dma_addr_i = 32'($urandom_range(0, 36));
                dma_len_i  = LENW'($urandom_range(0, 15));
            end
            dma_wdata_i = $urandom();
        end
        cyc();
        rst_n = 1'b1; core_req_i = 0; dma_req_i = 0;
        repeat (24) cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter/controller that shares the single-port data memory between the core load/store path and a DMA/debug port. Core accesses are single-word and complete at one per cycle; DMA accesses are locked bursts of 1–16 consecutive words with an auto-incrementing address. Round-robin fairness prevents either side from starving. Sits between the datapath/DMA engine and the data memory, driving its `addr`/`data`/`MemWrite`/`MemRead` inputs and capturing its read output.

## Interface
- `DEPTH`, 32: memory depth in words; word index ≥ DEPTH is out of range.
- `LENW`, 4: width of `dma_len`; maximum burst is 2^LENW words.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `core_req` in 1: core access request, held until granted.
- `core_we` in 1: 1 = write, 0 = read.
- `core_addr` in 32: word index.
- `core_wdata` in 32: write data.
- `core_gnt` out 1: access executes in this cycle.
- `core_rvalid` out 1: one-cycle pulse, one per granted access (reads and writes).
- `core_rdata` out 32: read data, valid with `core_rvalid`; 0 for writes.
- `core_err` out 1: with `core_rvalid`, access was out of range.
- `dma_req` in 1: burst request, held until granted.
- `dma_we` in 1: burst direction.
- `dma_addr` in 32: start word index.
- `dma_len` in LENW: beats minus 1.
- `dma_wdata` in 32: write data for the current beat.
- `dma_gnt` out 1: one-cycle pulse; burst accepted and its parameters latched.
- `dma_wready` out 1: a write beat consumes `dma_wdata` this cycle.
- `dma_rvalid` out 1: read beat data valid.
- `dma_rdata` out 32: read beat data.
- `dma_done` out 1: one-cycle pulse after the last beat.
- `dma_err` out 1: with `dma_done`, at least one beat was out of range.
- `mem_addr` out 32, `mem_wdata` out 32, `MemWrite` out 1, `MemRead` out 1: memory drive.
- `mem_rdata` in 32: combinational memory read output.

## Operation
- States: ARB (default) and BURST. Registers: `rr` (priority bit; 0 = core favoured), beat counter (LENW bits), burst address (32 bits), latched `dma_we`, sticky burst error.
- In ARB, grant is combinational. With only one request pending, that request is granted. With both pending, `rr` picks the winner. At most one grant per cycle.
- Core grant: the memory is driven in the same cycle with `core_addr`/`core_wdata`. `MemRead` = !we, `MemWrite` = we. `rr` becomes 1.
- DMA grant: `dma_gnt` pulses. The address, length, and direction are latched. The memory is idle that cycle. Next state is BURST.
- BURST: one beat per cycle at the burst address. The address increments by 1 and the counter decrements by 1 each beat. On the beat where the counter = 0, state returns to ARB and `rr` becomes 0.
- Write beats assert `dma_wready`. Read beats assert `MemRead`.
- `core_gnt` = 0 throughout BURST.
- Read data: `mem_rdata` is registered at the end of the access cycle. Core accesses return `core_rvalid`/`core_rdata`; DMA read beats return `dma_rvalid`/`dma_rdata`.
- Range check: a word index ≥ DEPTH suppresses `MemRead`/`MemWrite` for that access.
  - Core: `core_err` = 1 and `core_rdata` = 0.
  - DMA: the beat still takes its cycle (`dma_wready`/`dma_rvalid` still pulse, `dma_rdata` = 0), and the sticky error bit is set.
- Addresses are word indices and do not wrap.
- `dma_done` and `dma_err` are registered one cycle after the last beat. They coincide with the last `dma_rvalid` on read bursts. The sticky error clears on every `dma_gnt`.
- While `rst_n` = 0: state is ARB, `rr` = 0, and all grants and memory strobes are forced 0 combinationally, so a write in progress stops immediately. Every registered output is 0. A burst interrupted by reset is abandoned; no `dma_done` is produced.
- When no access is active: `mem_addr`/`mem_wdata` = 0 and both strobes are 0.

## Timing
- Core: `core_req` seen in cycle N with the arbiter free → `core_gnt` in N, `core_rvalid` in N+1. Back-to-back core accesses sustain one per cycle.
- DMA burst of L = `dma_len`+1 beats, granted in cycle N:
  - beats in N+1..N+L;
  - `dma_rvalid` in N+2..N+L+1;
  - `dma_done` in N+L+1.
- A core request can be granted in cycle N+L+1.
- Requester rule: drop or replace the request in the cycle after its grant. A request still asserted at the edge closing a grant cycle counts as a new request.

## Test plan
- Core write addr 5 = 0xDEADBEEF, then read addr 5 → `core_gnt` in the request cycle both times; read `core_rvalid` next cycle with 0xDEADBEEF and `core_err` = 0.
- After reset, `core_req` and `dma_req` rise together → core granted first (`rr` = 0). `dma_gnt` next cycle. While a second `core_req` is held, it is blocked until `dma_done`, then granted in the `dma_done` cycle.
- DMA write at addr 8, `dma_len` = 3, data 1..4, then DMA read of the same range:
  - write burst: `dma_wready` ×4 and `MemWrite` at 8, 9, 10, 11;
  - read burst returns 1, 2, 3, 4 in order; `dma_done` with the 4th `dma_rvalid`; `dma_err` = 0.
- Core read at addr 40 → no `MemRead`; `core_rvalid` with `core_err` = 1 and `core_rdata` = 0. DMA read at addr 30, `dma_len` = 3 → `MemRead` only for 30 and 31; four `dma_rvalid` pulses; `dma_done` with `dma_err` = 1.
- `rst_n` dropped after the 2nd beat of a 4-beat write → `MemWrite` falls in the same cycle and all outputs go to 0. After release, a new burst at addr 0 with `dma_len` = 0 completes normally with `dma_done` = 1.
- `core_req` held continuously with repeated single-beat DMA requests → grants alternate core, DMA burst, core, …; neither side waits longer than one opposing transaction.
